// File: rtl/clock_display_pkg.sv
// Shared definitions for the clock display back end: segment codes,
// digit slot numbering, field limits and the binary-to-BCD helper.
package clock_display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit slot numbering, rightmost digit first
    localparam logic [2:0] IDX_SEC_UNITS  = 3'd0;
    localparam logic [2:0] IDX_SEC_TENS   = 3'd1;
    localparam logic [2:0] IDX_MIN_UNITS  = 3'd2;
    localparam logic [2:0] IDX_MIN_TENS   = 3'd3;
    localparam logic [2:0] IDX_HOUR_UNITS = 3'd4;
    localparam logic [2:0] IDX_HOUR_TENS  = 3'd5;

    // Largest legal value of each time field
    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    // What the encoder should draw for the current digit
    typedef enum logic [1:0] {
        SEL_DIGIT,
        SEL_DASH,
        SEL_BLANK
    } seg_sel_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    // Split a 0..63 value into tens and units by subtracting 40, 20 and 10
    // in turn; after each step the remainder is below that weight.
    function automatic bcd_t bin_to_bcd(input logic [5:0] value);
        logic [5:0] rem;
        bcd_t       result;
        rem         = value;
        result.tens = 4'd0;
        if (rem >= 6'd40) begin
            rem         = rem - 6'd40;
            result.tens = result.tens + 4'd4;
        end
        if (rem >= 6'd20) begin
            rem         = rem - 6'd20;
            result.tens = result.tens + 4'd2;
        end
        if (rem >= 6'd10) begin
            rem         = rem - 6'd10;
            result.tens = result.tens + 4'd1;
        end
        result.units = rem[3:0];
        return result;
    endfunction

endpackage

// File: rtl/clock_display_mux_seg7_encoder.sv
// Combinational seven-segment encoder: one BCD digit, a dash or a blank.
module seg7_encoder
    import clock_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  seg_sel_t   sel,
    output logic [6:0] seg_n
);

    // Look up the active-low pattern; non-decimal codes fall back to blank
    always_comb begin
        seg_n = SEG_BLANK;
        case (sel)
            SEL_DIGIT: begin
                case (bcd)
                    4'd0:    seg_n = SEG_0;
                    4'd1:    seg_n = SEG_1;
                    4'd2:    seg_n = SEG_2;
                    4'd3:    seg_n = SEG_3;
                    4'd4:    seg_n = SEG_4;
                    4'd5:    seg_n = SEG_5;
                    4'd6:    seg_n = SEG_6;
                    4'd7:    seg_n = SEG_7;
                    4'd8:    seg_n = SEG_8;
                    4'd9:    seg_n = SEG_9;
                    default: seg_n = SEG_BLANK;
                endcase
            end
            SEL_DASH:  seg_n = SEG_DASH;
            default:   seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_display_mux.sv
// Six-digit multiplexed HH.MM.SS display driver. The time is frozen once per
// frame, each slot starts with a short all-off gap to avoid ghosting, and the
// separator points can blink on the 1 Hz enable. Outputs are registered.
module clock_display_mux
    import clock_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 4,
    parameter bit          BLINK     = 1'b1
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       clk_1hz_en,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    output logic [5:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    localparam logic [15:0] CNT_LAST   = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_END  = 16'(BLANK_CYC);
    localparam logic        COLON_INIT = (BLINK == 1'b1) ? 1'b0 : 1'b1;

    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [5:0]  snap_s;
    logic [5:0]  snap_m;
    logic [4:0]  snap_h;
    logic        colon;

    logic        slot_end;
    logic        frame_end;
    logic        anode_on;
    bcd_t        sec_bcd;
    bcd_t        min_bcd;
    bcd_t        hour_bcd;
    logic        sec_ok;
    logic        min_ok;
    logic        hour_ok;
    logic [3:0]  digit_bcd;
    seg_sel_t    digit_sel;
    logic [6:0]  digit_seg;
    logic [5:0]  an_next;
    logic        dp_next;

    function automatic seg_sel_t field_sel(input logic in_range);
        if (in_range) return SEL_DIGIT;
        return SEL_DASH;
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_HOUR_TENS);
    assign anode_on  = (cnt >= BLANK_END);

    // Prescaler counts out one slot, then the digit index moves on
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
            idx <= IDX_SEC_UNITS;
        end else if (slot_end) begin
            cnt <= 16'd0;
            idx <= (idx == IDX_HOUR_TENS) ? IDX_SEC_UNITS : idx + 3'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Freeze the time only at the frame wrap so a frame never mixes two values
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_s <= 6'd0;
            snap_m <= 6'd0;
            snap_h <= 5'd0;
        end else if (frame_end) begin
            snap_s <= seconds;
            snap_m <= minutes;
            snap_h <= hours;
        end
    end

    // Separator state: toggles on the 1 Hz pulse, or stays lit without blink
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            colon <= COLON_INIT;
        end else if (BLINK == 1'b0) begin
            colon <= 1'b1;
        end else if (clk_1hz_en) begin
            colon <= ~colon;
        end
    end

    assign sec_bcd  = bin_to_bcd(snap_s);
    assign min_bcd  = bin_to_bcd(snap_m);
    assign hour_bcd = bin_to_bcd({1'b0, snap_h});
    assign sec_ok   = (snap_s <= SEC_MAX);
    assign min_ok   = (snap_m <= MIN_MAX);
    assign hour_ok  = (snap_h <= HOUR_MAX);

    // Pick the BCD digit for the current slot; a bad field dashes both digits
    always_comb begin
        digit_bcd = 4'd0;
        digit_sel = SEL_BLANK;
        case (idx)
            IDX_SEC_UNITS:  begin digit_bcd = sec_bcd.units;  digit_sel = field_sel(sec_ok);  end
            IDX_SEC_TENS:   begin digit_bcd = sec_bcd.tens;   digit_sel = field_sel(sec_ok);  end
            IDX_MIN_UNITS:  begin digit_bcd = min_bcd.units;  digit_sel = field_sel(min_ok);  end
            IDX_MIN_TENS:   begin digit_bcd = min_bcd.tens;   digit_sel = field_sel(min_ok);  end
            IDX_HOUR_UNITS: begin digit_bcd = hour_bcd.units; digit_sel = field_sel(hour_ok); end
            IDX_HOUR_TENS:  begin digit_bcd = hour_bcd.tens;  digit_sel = field_sel(hour_ok); end
            default:        begin digit_bcd = 4'd0;           digit_sel = SEL_BLANK;          end
        endcase
    end

    seg7_encoder u_encoder (
        .bcd   (digit_bcd),
        .sel   (digit_sel),
        .seg_n (digit_seg)
    );

    assign an_next = anode_on ? ~(6'd1 << idx) : 6'h3F;
    assign dp_next = ~(colon && anode_on &&
                       ((idx == IDX_MIN_UNITS) || (idx == IDX_HOUR_UNITS)));

    // Register all pad outputs so they change cleanly one cycle after cnt/idx
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= 6'h3F;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= an_next;
            seg_n <= digit_seg;
            dp_n  <= dp_next;
        end
    end

endmodule
